// File: rtl/pri_enc_scanner.sv
// pri_enc_scanner: loads a request vector, then emits the index of each set
// bit, one per accepted handshake, in LSB-first or MSB-first order.
module pri_enc_scanner #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDXW     = $clog2(WIDTH),
    localparam int CNTW     = IDXW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             zero,
    output logic [CNTW-1:0]  served_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [IDXW-1:0]  enc_idx;
    logic [WIDTH-1:0] enc_sel;
    logic             single;
    logic             load;
    logic             accept;

    // Priority encoder over pending; later loop hits override earlier ones,
    // so the loop walks toward the bit that must win.
    always_comb begin
        enc_idx = '0;
        enc_sel = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (pending[i]) begin
                    enc_idx    = IDXW'(i);
                    enc_sel    = '0;
                    enc_sel[i] = 1'b1;
                end
            end else begin
                if (pending[WIDTH-1-i]) begin
                    enc_idx            = IDXW'(WIDTH - 1 - i);
                    enc_sel            = '0;
                    enc_sel[WIDTH-1-i] = 1'b1;
                end
            end
        end
    end

    // Exactly one pending bit left: current index is the final one.
    always_comb begin
        single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en && !rst;
                if (in_valid && in_ready && (in_vec != '0)) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                out_valid = en;
                if (out_valid && out_ready && single) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        load     = in_valid && in_ready;
        accept   = out_valid && out_ready;
        out_idx  = out_valid ? enc_idx : '0;
        out_last = out_valid && single;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending bits, served count and zero-vector pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            served_cnt <= '0;
            zero       <= 1'b0;
        end else begin
            zero <= load && (in_vec == '0);
            if (load) begin
                pending    <= in_vec;
                served_cnt <= '0;
            end else if (accept) begin
                pending    <= pending & ~enc_sel;
                served_cnt <= served_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pri_enc_scanner.sv
// Directed bench for pri_enc_scanner: an LSB-first and an MSB-first instance
// share all inputs; expected indices are queued at load and popped on accept.
module tb_pri_enc_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] in_vec = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       ready0, valid0, last0, zero0;
    logic [2:0] idx0;
    logic [3:0] cnt0;
    logic       ready1, valid1, last1, zero1;
    logic [2:0] idx1;
    logic [3:0] cnt1;

    typedef struct {
        int idx;
        int last;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pri_enc_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(ready0), .out_idx(idx0), .out_valid(valid0),
        .out_ready(out_ready), .out_last(last0), .zero(zero0), .served_cnt(cnt0)
    );

    pri_enc_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(ready1), .out_idx(idx1), .out_valid(valid1),
        .out_ready(out_ready), .out_last(last1), .zero(zero1), .served_cnt(cnt1)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Queue the expected index order for both scan directions.
    task automatic push_vec(input logic [7:0] v);
        int n;
        int k;
        exp_t e;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                e.idx = i; e.cnt = k; e.last = (k == n - 1) ? 1 : 0;
                q0.push_back(e);
                k++;
            end
        end
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                e.idx = i; e.cnt = k; e.last = (k == n - 1) ? 1 : 0;
                q1.push_back(e);
                k++;
            end
        end
    endtask

    // One clock: compare on the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (valid0 && out_ready) begin
            if (q0.size() == 0) chk("lsb_extra_valid", int'(valid0), 0);
            else begin
                e = q0.pop_front();
                chk("lsb_idx", int'(idx0), e.idx);
                chk("lsb_last", int'(last0), e.last);
                chk("lsb_cnt", int'(cnt0), e.cnt);
            end
        end
        if (valid1 && out_ready) begin
            if (q1.size() == 0) chk("msb_extra_valid", int'(valid1), 0);
            else begin
                e = q1.pop_front();
                chk("msb_idx", int'(idx1), e.idx);
                chk("msb_last", int'(last1), e.last);
                chk("msb_cnt", int'(cnt1), e.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        push_vec(v);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_q0_left"}, q0.size(), 0);
        chk({tag, "_q1_left"}, q1.size(), 0);
    endtask

    initial begin
        // Reset held: everything quiet, in_ready low despite en.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(ready0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_idx", int'(idx0), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_zero", int'(zero0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(ready0), 1);

        // 00101010, out_ready high: three back-to-back indices.
        out_ready = 1'b1;
        load(8'b00101010);
        repeat (3) cycle();
        drained("seq2a");
        chk("seq2a_cnt", int'(cnt0), 3);
        chk("seq2a_idle_ready", int'(ready0), 1);
        chk("seq2a_idle_valid", int'(valid0), 0);

        // All-zero vector: one-cycle zero pulse, no scan.
        load(8'h00);
        @(negedge clk);
        chk("zero_pulse", int'(zero0), 1);
        chk("zero_no_valid", int'(valid0), 0);
        chk("zero_ready", int'(ready0), 1);
        chk("zero_cnt_cleared", int'(cnt0), 0);
        @(posedge clk);
        #1;
        cycle();
        chk("zero_pulse_end", int'(zero0), 0);
        chk("zero_still_idle", int'(valid0), 0);

        // 10000001 with backpressure: outputs hold for three cycles.
        out_ready = 1'b0;
        load(8'b10000001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(valid0), 1);
            chk("bp_idx_lsb", int'(idx0), 0);
            chk("bp_last_lsb", int'(last0), 0);
            chk("bp_cnt", int'(cnt0), 0);
            chk("bp_idx_msb", int'(idx1), 7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (2) cycle();
        drained("bp");

        // All ones: full sweep in both directions, count reaches WIDTH.
        load(8'hFF);
        repeat (8) cycle();
        drained("ff");
        chk("ff_cnt_lsb", int'(cnt0), 8);
        chk("ff_cnt_msb", int'(cnt1), 8);

        // 00011100 with en dropped after the first accept.
        load(8'b00011100);
        cycle();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("en_off_valid", int'(valid0), 0);
            chk("en_off_idx", int'(idx0), 0);
            chk("en_off_last", int'(last0), 0);
            chk("en_off_cnt", int'(cnt0), 1);
            chk("en_off_ready", int'(ready0), 0);
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        repeat (2) cycle();
        drained("en");

        // en low in IDLE: in_valid ignored, no zero pulse, no scan.
        en = 1'b0;
        in_vec = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_en_off_ready", int'(ready0), 0);
        @(posedge clk);
        #1;
        in_vec = 8'h05;
        @(negedge clk);
        chk("idle_en_off_zero", int'(zero0), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("idle_en_off_noscan", int'(valid0), 0);
        @(posedge clk);
        #1;

        // 11110000, reset after index 4 is accepted, then reload 00000100.
        load(8'b11110000);
        cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", int'(valid0), 0);
        chk("abort_idx", int'(idx0), 0);
        chk("abort_last", int'(last0), 0);
        chk("abort_cnt", int'(cnt0), 0);
        chk("abort_ready", int'(ready0), 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rel_ready", int'(ready0), 1);
        load(8'b00000100);
        cycle();
        drained("reload");
        cycle();
        chk("reload_idle", int'(valid0), 0);
        chk("reload_cnt", int'(cnt0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
